// File: rtl/pe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : pe_pkg                                                            |
// | Purpose : Shared types and constants for the pe_alu_xbar PE datapath slice: |
// |           default datapath width, ALU opcode enum, crossbar source enum and |
// |           the bit layout of the 13-bit serial configuration word.           |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package pe_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Configuration word layout (LSB offsets and field widths)
  localparam int CFG_LEN  = 13;
  localparam int OP_LSB   = 0;
  localparam int OP_W     = 4;
  localparam int OSEL_LSB = 4;
  localparam int SEL_W    = 2;
  localparam int SEL0_LSB = 5;
  localparam int SEL1_LSB = 7;
  localparam int SEL2_LSB = 9;
  localparam int SEL3_LSB = 11;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_EQ   = 4'd9,
    OP_LTS  = 4'd10,
    OP_LTU  = 4'd11,
    OP_PASA = 4'd12,
    OP_PASB = 4'd13,
    OP_MIN  = 4'd14,
    OP_MAX  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    SRC_IN0 = 2'd0,
    SRC_IN1 = 2'd1,
    SRC_ALU = 2'd2,
    SRC_MEM = 2'd3
  } xbar_src_e;

endpackage

`default_nettype wire

// File: rtl/alu2_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu2_core                                                         |
// | Purpose : Purely combinational two-operand ALU, y = f(op, a, b).            |
// |           Arithmetic wraps modulo 2^WIDTH; compares return 0/1 zero-ext.    |
// | Ports   : op (opcode_e), a, b (WIDTH) in; y (WIDTH) out.                    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module alu2_core
  import pe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  opcode_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int SHW = $clog2(WIDTH);

  // Shift amount uses only the low log2(WIDTH) bits of b
  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_SRA:  y = $signed(a) >>> shamt;
      OP_EQ:   y = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_LTS:  y = {{(WIDTH-1){1'b0}}, lt_s};
      OP_LTU:  y = {{(WIDTH-1){1'b0}}, lt_u};
      OP_PASA: y = a;
      OP_PASB: y = b;
      OP_MIN:  y = lt_s ? a : b;
      OP_MAX:  y = lt_s ? b : a;
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pe_alu_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pe_alu_xbar                                                       |
// | Purpose : CGRA processing-element datapath slice. A 4x4 crossbar routes     |
// |           {in0, in1, alu_q, mem_in} to the ALU operands and two memory      |
// |           operand lanes; out0 selects alu_q or mem_in. All routing and the  |
// |           opcode come from a 13-bit serial config shift chain.              |
// | Ports   : clk, reset (async, active-low)                                    |
// |           config_en, config_in in / config_out out (chain MSB)              |
// |           in0, in1, mem_in (WIDTH) in                                       |
// |           mem_op0, mem_op1, out0 (WIDTH) out                                |
// | Notes   : WIDTH must be >= 8 and a power of two.                            |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module pe_alu_xbar
  import pe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             config_en,
  input  logic             config_in,
  output logic             config_out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] mem_in,
  output logic [WIDTH-1:0] mem_op0,
  output logic [WIDTH-1:0] mem_op1,
  output logic [WIDTH-1:0] out0
);

  logic [CFG_LEN-1:0] cfg_q;
  logic [WIDTH-1:0]   alu_q;
  logic [WIDTH-1:0]   alu_d;
  logic [WIDTH-1:0]   xbar_src [4];
  logic [WIDTH-1:0]   xbar_out [4];
  opcode_e            op;

  // Crossbar sources, indexed by xbar_src_e encoding. alu_q is registered,
  // so routing it back onto the ALU operands forms no combinational loop.
  assign xbar_src[SRC_IN0] = in0;
  assign xbar_src[SRC_IN1] = in1;
  assign xbar_src[SRC_ALU] = alu_q;
  assign xbar_src[SRC_MEM] = mem_in;

  // Select fields for outputs 0..3 are packed contiguously from SEL0_LSB;
  // partially shifted fields take effect immediately.
  generate
    for (genvar k = 0; k < 4; k++) begin : g_xbar
      assign xbar_out[k] = xbar_src[cfg_q[SEL0_LSB + SEL_W*k +: SEL_W]];
    end
  endgenerate

  assign op = opcode_e'(cfg_q[OP_LSB +: OP_W]);

  alu2_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op (op),
    .a  (xbar_out[0]),
    .b  (xbar_out[1]),
    .y  (alu_d)
  );

  // Config chain shifts MSB-first; the ALU keeps computing while it shifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q <= '0;
      alu_q <= '0;
    end else begin
      if (config_en) begin
        cfg_q <= {cfg_q[CFG_LEN-2:0], config_in};
      end
      alu_q <= alu_d;
    end
  end

  assign config_out = cfg_q[CFG_LEN-1];
  assign mem_op0    = xbar_out[2];
  assign mem_op1    = xbar_out[3];
  assign out0       = cfg_q[OSEL_LSB] ? mem_in : alu_q;

  // Field sanity: the top select field must end exactly at the chain MSB.
  generate
    if (SEL3_LSB + SEL_W != CFG_LEN) begin : g_cfg_layout_bad
      cfg_layout_mismatch u_bad ();
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pe_alu_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pe_alu_xbar                                                    |
// | Purpose : Self-checking bench for pe_alu_xbar: directed scenarios plus      |
// |           randomized data/config traffic against a behavioural model.      |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_pe_alu_xbar;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         config_en;
  logic         config_in;
  logic         config_out;
  logic [W-1:0] in0, in1, mem_in;
  logic [W-1:0] mem_op0, mem_op1, out0;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: config word and registered ALU result
  logic [12:0]  m_s;
  logic [W-1:0] m_q;

  pe_alu_xbar #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .in0        (in0),
    .in1        (in1),
    .mem_in     (mem_in),
    .mem_op0    (mem_op0),
    .mem_op1    (mem_op1),
    .out0       (out0)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] cfg(input int op, input int osel, input int s0,
                                      input int s1, input int s2, input int s3);
    logic [12:0] w;
    w = 13'(op) | (13'(osel) << 4) | (13'(s0) << 5) | (13'(s1) << 7) |
        (13'(s2) << 9) | (13'(s3) << 11);
    return w;
  endfunction

  function automatic logic [W-1:0] src_val(input int sel);
    case (sel)
      0:       return in0;
      1:       return in1;
      2:       return m_q;
      default: return mem_in;
    endcase
  endfunction

  function automatic int sel_of(input int k);
    return int'((m_s >> (5 + 2*k)) & 13'd3);
  endfunction

  function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sh;
    logic signed [W-1:0] sa, sb;
    sh = int'(b % W);
    sa = a;
    sb = b;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return W'(a * b);
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return a << sh;
      7:  return a >> sh;
      8:  return W'(sa >>> sh);
      9:  return (a == b) ? 1 : 0;
      10: return (sa < sb) ? 1 : 0;
      11: return (a < b) ? 1 : 0;
      12: return a;
      13: return b;
      14: return (sa < sb) ? a : b;
      default: return (sa < sb) ? b : a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model
  task automatic chk_all(input string tag);
    chk({tag, ".out0"}, out0, m_s[4] ? mem_in : m_q);
    chk({tag, ".mem_op0"}, mem_op0, src_val(sel_of(2)));
    chk({tag, ".mem_op1"}, mem_op1, src_val(sel_of(3)));
    chk({tag, ".config_out"}, W'(config_out), W'(m_s[12]));
  endtask

  // One clock with the current inputs; model advances in step
  task automatic tick();
    logic [W-1:0] nq;
    nq = ref_alu(int'(m_s[3:0]), src_val(sel_of(0)), src_val(sel_of(1)));
    @(posedge clk);
    #1;
    m_q = nq;
    if (config_en) m_s = {m_s[11:0], config_in};
  endtask

  task automatic load_cfg(input logic [12:0] w);
    for (int i = 12; i >= 0; i--) begin
      config_en = 1'b1;
      config_in = w[i];
      tick();
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  initial begin
    logic [12:0]  word;
    logic [3:0]   ops [7];
    logic [W-1:0] exps [7];

    // ---------------- Reset state ----------------
    reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
    in0 = 32'd5; in1 = '0; mem_in = '0;
    m_s = '0; m_q = '0;
    #2;
    chk("rst.out0", out0, 32'd0);
    chk("rst.config_out", W'(config_out), 32'd0);
    chk("rst.mem_op0", mem_op0, 32'd5);
    chk("rst.mem_op1", mem_op1, 32'd5);
    reset = 1'b1;
    tick();
    chk("rst.first_add", out0, 32'd10);

    // ---------------- Config shift and readout ----------------
    word = 13'h1A5C;
    load_cfg(word);
    chk_all("cfg.loaded");
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("cfg.out_bit%0d", i), W'(config_out), W'(word[12-i]));
      config_en = 1'b1;
      config_in = 1'b0;
      tick();
    end
    config_en = 1'b0;
    chk_all("cfg.flushed");

    // ---------------- Directed ALU ops ----------------
    ops  = '{4'd1, 4'd8, 4'd7, 4'd10, 4'd11, 4'd2, 4'd14};
    exps = '{32'hFFFF_FFEC, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'd1, 32'd0,
             32'hFFFF_FFC0, 32'hFFFF_FFF0};
    in0 = 32'hFFFF_FFF0; in1 = 32'd4; mem_in = 32'd0;
    for (int i = 0; i < 7; i++) begin
      load_cfg(cfg(int'(ops[i]), 0, 0, 1, 0, 0));
      tick();
      chk($sformatf("alu.op%0d", ops[i]), out0, exps[i]);
    end

    // ---------------- Accumulator feedback ----------------
    in0 = '0; in1 = '0; mem_in = '0;
    reset = 1'b0; #1; reset = 1'b1;
    m_s = '0; m_q = '0;
    load_cfg(cfg(0, 0, 2, 1, 0, 0));
    chk("acc.start", out0, 32'd0);
    in1 = 32'd3;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("acc.step%0d", i), out0, W'(3 * i));
    end

    // ---------------- Async reset mid-accumulation ----------------
    #3;
    reset = 1'b0;
    #1;
    m_s = '0; m_q = '0;
    chk("areset.out0", out0, 32'd0);
    chk("areset.config_out", W'(config_out), 32'd0);
    chk("areset.mem_op0", mem_op0, in0);
    #1;
    reset = 1'b1;
    load_cfg(cfg(0, 0, 2, 1, 0, 0));
    tick();
    chk("areset.restart1", out0, 32'd3);
    tick();
    chk("areset.restart2", out0, 32'd6);

    // ---------------- Memory routing ----------------
    load_cfg(cfg(0, 1, 0, 1, 1, 3));
    in1 = 32'd7; mem_in = 32'd42;
    #1;
    chk("mem.op0", mem_op0, 32'd7);
    chk("mem.op1", mem_op1, 32'd42);
    chk("mem.out0", out0, 32'd42);
    load_cfg(cfg(0, 0, 0, 1, 1, 3));
    chk_all("mem.osel0");

    // ---------------- Randomized traffic vs model ----------------
    for (int it = 0; it < 300; it++) begin
      in0    = $urandom;
      in1    = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 40)) : W'($urandom);
      mem_in = $urandom;
      if ((it % 40) == 0) begin
        load_cfg(13'($urandom));
      end else begin
        config_en = ($urandom_range(0, 3) == 0);
        config_in = 1'($urandom);
      end
      #1;
      chk_all($sformatf("rnd%0d.comb", it));
      tick();
      chk_all($sformatf("rnd%0d.seq", it));
    end
    config_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
